// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and LFSR helpers for the rng_arbiter block.
package rng_pkg;

  localparam logic [31:0] RNG_POLY     = 32'h8020_0003;
  localparam logic [31:0] RNG_SEED_DEF = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WARM = 2'd2
  } rng_state_e;

  // An all-zero state would lock the Galois LFSR, so zero seeds become the default seed.
  function automatic logic [31:0] rng_fix_seed(input logic [31:0] s);
    return (s == 32'd0) ? RNG_SEED_DEF : s;
  endfunction

  function automatic logic [31:0] rng_step(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? RNG_POLY : 32'd0);
  endfunction

endpackage

// File: rtl/rng_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; load has priority over step.
module rng_lfsr32
  import rng_pkg::*;
#(
  parameter logic [31:0] SEED_RST = RNG_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [31:0] ld_val,
  input  logic        en,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = rng_fix_seed(ld_val);
    end else if (en) begin
      q_d = rng_step(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= rng_fix_seed(SEED_RST);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among N_REQ requesters, one fresh draw per grant.
// Optional warm-up after reset/reseed is enabled with `define RNG_ARB_WARMUP_EN.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter logic [31:0] SEED_RST = RNG_SEED_DEF,
  parameter int          WARMUP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             reseed,
  input  logic [31:0]      seed_in,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic [31:0]      dout,
  output logic             busy
);

  localparam int               PTR_W    = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

`ifdef RNG_ARB_WARMUP_EN
  localparam rng_state_e  ST_RST    = ST_WARM;
  localparam logic [15:0] WARM_INIT = 16'(WARMUP - 1);
  logic [15:0] warm_cnt_q;
`else
  localparam rng_state_e  ST_RST    = ST_IDLE;
`endif

  rng_state_e       state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             pend_q;
  logic [31:0]      seed_q;
  logic [N_REQ-1:0] gnt_q;
  logic             valid_q;
  logic [31:0]      dout_q;

  logic [31:0]      lfsr_q;
  logic [31:0]      ld_val;
  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic             svc_reseed;
  logic             do_grant;
  logic             lfsr_en;

  // First requester at or after ptr_q, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    win     = ptr_q;
    win_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!win_vld && req[PTR_W'(idx)]) begin
        win     = PTR_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // A reseed arriving in the same cycle blocks the grant and, if a reseed is
  // already being serviced, supplies the newer seed directly.
  assign svc_reseed = (state_q == ST_IDLE) && pend_q;
  assign do_grant   = (state_q == ST_IDLE) && !pend_q && !reseed && win_vld;
  assign ld_val     = reseed ? seed_in : seed_q;

`ifdef RNG_ARB_WARMUP_EN
  assign lfsr_en = do_grant || (state_q == ST_WARM);
`else
  assign lfsr_en = do_grant;
`endif

  rng_lfsr32 #(
    .SEED_RST(SEED_RST)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (svc_reseed),
    .ld_val(ld_val),
    .en    (lfsr_en),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      seed_q     <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
`ifdef RNG_ARB_WARMUP_EN
      warm_cnt_q <= WARM_INIT;
`endif
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;

      if (reseed) begin
        seed_q <= seed_in;
      end
      if (svc_reseed) begin
        pend_q <= 1'b0;
      end else if (reseed) begin
        pend_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (svc_reseed) begin
`ifdef RNG_ARB_WARMUP_EN
            state_q    <= ST_WARM;
            warm_cnt_q <= WARM_INIT;
`else
            state_q    <= ST_IDLE;
`endif
          end else if (do_grant) begin
            gnt_q   <= N_REQ'(1) << win;
            valid_q <= 1'b1;
            dout_q  <= lfsr_q;
            ptr_q   <= (win == PTR_LAST) ? '0 : win + PTR_W'(1);
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
`ifdef RNG_ARB_WARMUP_EN
        ST_WARM: begin
          if (warm_cnt_q == 16'd0) begin
            state_q <= ST_IDLE;
          end else begin
            warm_cnt_q <= warm_cnt_q - 16'd1;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign dout  = dout_q;
  assign busy  = (state_q != ST_IDLE) || pend_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_rng_arbiter;

  localparam int          N    = 4;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam int          WU   = 16;
`ifdef RNG_ARB_WARMUP_EN
  localparam int WSTEPS = WU;
`else
  localparam int WSTEPS = 0;
`endif

  localparam int PH_RUN  = 0;
  localparam int PH_COOL = 1;
  localparam int PH_WARM = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          reseed;
  logic [31:0]   seed_in;
  logic [N-1:0]  gnt;
  logic          valid;
  logic [31:0]   dout;
  logic          busy;

  always #5 clk = ~clk;

  rng_arbiter #(
    .N_REQ   (N),
    .SEED_RST(SEED),
    .WARMUP  (WU)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .reseed (reseed),
    .seed_in(seed_in),
    .gnt    (gnt),
    .valid  (valid),
    .dout   (dout),
    .busy   (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] nxt(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] v, input int k);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = nxt(r);
    return r;
  endfunction

  function automatic logic [31:0] nz(input logic [31:0] v);
    return (v == 32'd0) ? 32'h0000_0001 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_grant(input string nm, input int lim, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (valid !== 1'b1 && waited < lim);
    if (valid !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no grant within %0d cycles", nm, lim);
    end
  endtask

  // Behavioural model: the generator advances once per grant (and per warm-up
  // step), a grant is followed by one quiet cycle, and a pending reseed beats requests.
  logic [31:0]  m_lfsr, m_seed, e_dout;
  logic [N-1:0] e_gnt;
  bit           e_valid, m_pend, consumed;
  int           m_ptr, m_phase, m_warm, m_w, m_idx;
  logic [31:0]  rq32;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  = nz(SEED);
      m_seed  = '0;
      m_pend  = 0;
      m_ptr   = 0;
      e_gnt   = '0;
      e_valid = 0;
      e_dout  = '0;
      m_phase = (WSTEPS > 0) ? PH_WARM : PH_RUN;
      m_warm  = WSTEPS;
    end else begin
      e_gnt    = '0;
      e_valid  = 0;
      consumed = 0;
      if (m_phase == PH_COOL) begin
        m_phase = PH_RUN;
      end else if (m_phase == PH_WARM) begin
        m_lfsr = nxt(m_lfsr);
        m_warm--;
        if (m_warm == 0) m_phase = PH_RUN;
      end else if (m_pend) begin
        m_lfsr   = nz(reseed ? seed_in : m_seed);
        m_pend   = 0;
        consumed = reseed;
        if (WSTEPS > 0) begin
          m_phase = PH_WARM;
          m_warm  = WSTEPS;
        end
      end else if (!reseed && req != '0) begin
        rq32 = 32'(req);
        m_w  = -1;
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (m_w < 0 && ((rq32 >> m_idx) & 32'd1) != 32'd0) m_w = m_idx;
        end
        e_gnt   = N'(1) << m_w;
        e_valid = 1;
        e_dout  = m_lfsr;
        m_lfsr  = nxt(m_lfsr);
        m_ptr   = (m_w + 1) % N;
        m_phase = PH_COOL;
      end
      if (reseed) begin
        m_seed = seed_in;
        if (!consumed) m_pend = 1;
      end
    end
  end

  bit prev_v = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("valid", 32'(valid), 32'(e_valid));
      chk("dout", dout, e_dout);
      chk("busy", 32'(busy), 32'((m_phase != PH_RUN) || m_pend));
      if (valid === 1'b1) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        chk("gnt_back_to_back", 32'(prev_v), 32'd0);
      end
      prev_v = (valid === 1'b1);
    end else begin
      prev_v = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [31:0] exp0, exp1, exp2;
    logic [N-1:0] order [4];
`ifdef RNG_ARB_WARMUP_EN
    exp0 = adv(nz(SEED), WSTEPS);
    exp1 = adv(nz(SEED), WSTEPS + 1);
    exp2 = adv(nz(SEED), WSTEPS + 2);
`else
    exp0 = 32'h0000_0001;
    exp1 = 32'h8020_0003;
    exp2 = 32'hC030_0002;
`endif
    order[0] = 4'b0010;
    order[1] = 4'b0100;
    order[2] = 4'b1000;
    order[3] = 4'b0001;

    rst_n   = 1'b0;
    req     = '0;
    reseed  = 1'b0;
    seed_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_busy", 32'(busy), 32'(WSTEPS > 0));

    // Single requester held: consecutive draws of the generator.
    rst_n = 1'b1;
    req   = 4'b0001;
    wait_grant("first_grant", 60, waited);
    chk("first_latency", 32'(waited), 32'(WSTEPS + 1));
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_dout", dout, exp0);
    wait_grant("second_grant", 10, waited);
    chk("second_spacing", 32'(waited), 32'd2);
    chk("second_dout", dout, exp1);
    wait_grant("third_grant", 10, waited);
    chk("third_spacing", 32'(waited), 32'd2);
    chk("third_dout", dout, exp2);
    req = '0;
    repeat (2) @(negedge clk);

    // Zero-seed reseed together with a request.
    reseed  = 1'b1;
    seed_in = 32'd0;
    req     = 4'b0001;
    @(negedge clk);
    reseed  = 1'b0;
    seed_in = 32'h5555_AAAA;
    chk("rs_pulse_nogrant", 32'(valid), 32'd0);
    @(negedge clk);
    chk("rs_service_nogrant", 32'(valid), 32'd0);
    wait_grant("rs_grant", 60, waited);
    chk("rs_latency", 32'(waited), 32'(WSTEPS + 1));
    chk("rs_dout", dout, adv(32'h0000_0001, WSTEPS));

    // Two reseeds back to back right after a grant: the later seed is used.
    reseed  = 1'b1;
    seed_in = 32'h1234_5678;
    @(negedge clk);
    seed_in = 32'hDEAD_BEEF;
    @(negedge clk);
    reseed  = 1'b0;
    seed_in = '0;
    chk("rs2_service_nogrant", 32'(valid), 32'd0);
    wait_grant("rs2_grant", 60, waited);
    chk("rs2_latency", 32'(waited), 32'(WSTEPS + 1));
    chk("rs2_dout", dout, adv(32'hDEAD_BEEF, WSTEPS));
    req = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while a grant is on the outputs.
    req = 4'b1111;
    wait_grant("pre_rst_grant", 10, waited);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant("post_rst_grant", 60, waited);
    chk("post_rst_latency", 32'(waited), 32'(WSTEPS + 1));
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    for (int g = 0; g < 4; g++) begin
      wait_grant("rr_grant", 10, waited);
      chk("rr_spacing", 32'(waited), 32'd2);
      chk("rr_order", 32'(gnt), 32'(order[g]));
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic, reseeds and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(99) < 25) req = N'($urandom);
      reseed  = ($urandom_range(99) < 3);
      seed_in = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      if (c == 1500 || c == 3000) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    reseed = 1'b0;
    req    = '0;
    repeat (WSTEPS + 5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
